// File: rtl/dmi_reg_responder_pkg.sv
// Shared DMI types for the core-side DMI register responder.
//   dtm_op_e    : DMI operation code (NOP/READ/WRITE; 2'h3 is reserved)
//   dmi_req_t   : {addr[6:0], op[1:0], data[31:0]}, 41 bits
//   dmi_resp_t  : {data[31:0], resp[1:0]}, 34 bits
//   DMI_RESP_*  : response codes carried in dmi_resp_t.resp
//   in_window() : 8-bit wide, non-wrapping address window test
package dmi_reg_responder_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  localparam logic [1:0] DMI_RESP_OK     = 2'h0;
  localparam logic [1:0] DMI_RESP_FAILED = 2'h2;
  localparam logic [1:0] DMI_RESP_BUSY   = 2'h3;

  // Widened to 8 bits so that base + size up to 128 can never wrap.
  function automatic logic in_window(input logic [6:0] addr,
                                     input logic [7:0] base,
                                     input logic [7:0] size);
    logic [7:0] a;
    a = {1'b0, addr};
    return (a >= base) && ((a - base) < size);
  endfunction

endpackage

// File: rtl/dmi_reg_responder.sv
// Core-side DMI target. Accepts one dmi_req_t at a time, turns READ/WRITE
// inside the address window into a single req/gnt/rvalid register-bus
// access and returns a dmi_resp_t. NOP is answered OK at once; reserved ops
// and out-of-window addresses are answered FAILED at once. A bus access that
// exceeds TimeoutCycles is aborted and answered FAILED.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   dmi_req_i/_valid_i/_ready_o       request channel (valid/ready)
//   dmi_resp_o/_valid_o/_ready_i      response channel, held until ready
//   bus_req_o/we_o/addr_o/wdata_o     register-bus request, held until gnt
//   bus_gnt_i/rvalid_i/rdata_i/err_i  register-bus grant and completion
//   busy_o                            high while a transaction is open
//   err_cnt_o                         saturating count of FAILED responses
// All outputs come straight from flops.
module dmi_reg_responder
  import dmi_reg_responder_pkg::*;
#(
  parameter logic [6:0]  WinBase       = 7'h04,
  parameter int unsigned WinSize       = 64,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  dmi_req_t    dmi_req_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  output dmi_resp_t   dmi_resp_o,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [6:0]  bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        busy_o,
  output logic [7:0]  err_cnt_o
);

  localparam logic [7:0]  WinBaseW  = {1'b0, WinBase};
  localparam logic [7:0]  WinSizeW  = 8'(WinSize);
  localparam logic [15:0] TimeoutW  = 16'(TimeoutCycles);
  localparam dmi_resp_t   RespFail  = '{data: 32'h0, resp: DMI_RESP_FAILED};
  localparam dmi_resp_t   RespOkNil = '{data: 32'h0, resp: DMI_RESP_OK};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS_REQ  = 2'd1,
    ST_BUS_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  dmi_req_t    req_q, req_d;
  dmi_resp_t   resp_q, resp_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        ready_q, ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic        busy_q, busy_d;
  logic [15:0] tmo_inc;
  logic        tmo_hit;

  // Next-state, latched request/response, timeout and error counters.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;
    err_cnt_d = err_cnt_q;
    tmo_inc   = tmo_q + 16'd1;
    // tmo_q counts completed bus cycles, so the hit fires in the last allowed cycle.
    tmo_hit   = (tmo_inc == TimeoutW);

    unique case (state_q)
      ST_IDLE: begin
        if (dmi_req_valid_i) begin
          req_d  = dmi_req_i;
          tmo_d  = 16'd0;
          resp_d = RespOkNil;
          unique case (dmi_req_i.op)
            DTM_NOP: begin
              state_d = ST_RESP;
            end
            DTM_READ, DTM_WRITE: begin
              if (in_window(dmi_req_i.addr, WinBaseW, WinSizeW)) begin
                state_d = ST_BUS_REQ;
              end else begin
                resp_d  = RespFail;
                state_d = ST_RESP;
              end
            end
            default: begin
              resp_d  = RespFail;
              state_d = ST_RESP;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS_REQ: begin
        tmo_d = tmo_inc;
        // Abort beats a grant arriving in the very last allowed cycle.
        if (tmo_hit) begin
          resp_d  = RespFail;
          state_d = ST_RESP;
        end else if (bus_gnt_i) begin
          state_d = ST_BUS_WAIT;
        end else begin
          state_d = ST_BUS_REQ;
        end
      end
      ST_BUS_WAIT: begin
        tmo_d = tmo_inc;
        // Completion beats timeout when both land in the same cycle.
        if (bus_rvalid_i) begin
          if (bus_err_i) begin
            resp_d = RespFail;
          end else if (req_q.op == DTM_READ) begin
            resp_d = '{data: bus_rdata_i, resp: DMI_RESP_OK};
          end else begin
            resp_d = RespOkNil;
          end
          state_d = ST_RESP;
        end else if (tmo_hit) begin
          resp_d  = RespFail;
          state_d = ST_RESP;
        end else begin
          state_d = ST_BUS_WAIT;
        end
      end
      ST_RESP: begin
        if (dmi_resp_ready_i) begin
          state_d = ST_IDLE;
          if ((resp_q.resp == DMI_RESP_FAILED) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_d      = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    bus_req_d    = (state_d == ST_BUS_REQ);
    resp_valid_d = (state_d == ST_RESP);
    bus_we_d     = (req_d.op == DTM_WRITE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      resp_q       <= '0;
      tmo_q        <= 16'd0;
      err_cnt_q    <= 8'd0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      resp_q       <= resp_d;
      tmo_q        <= tmo_d;
      err_cnt_q    <= err_cnt_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      busy_q       <= busy_d;
    end
  end

  assign dmi_req_ready_o  = ready_q;
  assign dmi_resp_o       = resp_q;
  assign dmi_resp_valid_o = resp_valid_q;
  assign bus_req_o        = bus_req_q;
  assign bus_we_o         = bus_we_q;
  assign bus_addr_o       = req_q.addr;
  assign bus_wdata_o      = req_q.data;
  assign busy_o           = busy_q;
  assign err_cnt_o        = err_cnt_q;

endmodule

// File: tb/tb_dmi_reg_responder.sv
// Self-checking bench for dmi_reg_responder (TimeoutCycles = 8).
module tb_dmi_reg_responder;
  import dmi_reg_responder_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  dmi_req_t    req_i;
  logic        req_valid, req_ready;
  dmi_resp_t   resp_o;
  logic        resp_valid, resp_ready;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err, busy;
  logic [6:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  dmi_reg_responder #(.WinBase(7'h04), .WinSize(64), .TimeoutCycles(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dmi_req_i(req_i), .dmi_req_valid_i(req_valid), .dmi_req_ready_o(req_ready),
    .dmi_resp_o(resp_o), .dmi_resp_valid_o(resp_valid), .dmi_resp_ready_i(resp_ready),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err),
    .busy_o(busy), .err_cnt_o(err_cnt)
  );

  // Reference: expected response, cycles from accept to resp_valid, bus_req cycles.
  // g = grant on the (g+1)-th bus_req cycle (g<0: never), r = rvalid r cycles after grant.
  function automatic void model(input logic [1:0] op, input logic [6:0] addr, input int g,
                                input int r, input logic e, input logic [31:0] rd,
                                output logic [33:0] rsp, output int lat, output int reqc);
    int a;
    int gw;
    bit win;
    a   = int'(addr);
    win = (a >= 4) && (a < 4 + 64);
    if (op == 2'd0) begin
      rsp = {32'h0, 2'h0}; lat = 1; reqc = 0;
    end else if (op == 2'd3 || !win) begin
      rsp = {32'h0, 2'h2}; lat = 1; reqc = 0;
    end else begin
      gw = (g < 0) ? 1000 : g;
      if (gw + 1 >= TMO) begin
        rsp = {32'h0, 2'h2}; lat = TMO + 1; reqc = TMO;
      end else if (gw + 1 + r > TMO) begin
        rsp = {32'h0, 2'h2}; lat = TMO + 1; reqc = gw + 1;
      end else begin
        lat  = gw + r + 2;
        reqc = gw + 1;
        rsp  = e ? {32'h0, 2'h2} : {((op == 2'd1) ? rd : 32'h0), 2'h0};
      end
    end
  endfunction

  // Driver: called at a negedge; runs one transaction through response handshake.
  task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                        input int g, input int r, input logic e, input logic [31:0] rd,
                        input int hold, output logic [33:0] rsp, output int lat, output int reqc,
                        output bit flds_ok, output bit rdy_low_ok, output bit stable_ok,
                        output logic rdy_acc, output logic rdy_after, output logic vld_after);
    int gc;
    int h;
    bit seen;
    gc = -1; h = 0; seen = 1'b0; lat = -1; reqc = 0; rsp = '0;
    flds_ok = 1'b1; rdy_low_ok = 1'b1; stable_ok = 1'b1;
    rdy_acc = req_ready;
    req_i.addr = addr; req_i.op = dtm_op_e'(op); req_i.data = data;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_i = '0;
    for (int t = 1; t < 400; t++) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0; resp_ready = 1'b0;
      if (!seen && resp_valid) begin
        seen = 1'b1; lat = t; rsp = resp_o;
      end
      if (req_ready) rdy_low_ok = 1'b0;
      if (bus_req) begin
        reqc++;
        if (bus_we !== (op == 2'd2) || bus_addr !== addr || bus_wdata !== data) flds_ok = 1'b0;
        if (g >= 0 && reqc == g + 1) begin
          bus_gnt = 1'b1; gc = t;
        end
      end
      if (gc >= 0 && t == gc + r) begin
        bus_rvalid = 1'b1; bus_err = e; bus_rdata = rd;
      end
      if (seen) begin
        if (resp_o !== rsp || resp_valid !== 1'b1) stable_ok = 1'b0;
        if (h == hold) resp_ready = 1'b1;
        h++;
      end
      @(negedge clk);
      if (h > hold) break;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; resp_ready = 1'b0;
    rdy_after = req_ready;
    vld_after = resp_valid;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; req_valid = 1'b0; req_i = '0; resp_ready = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({req_ready, resp_valid, bus_req, bus_we, busy} !== 5'b10000) begin
      n_err++; $display("FAIL reset_ctrl got %b want 10000", {req_ready, resp_valid, bus_req, bus_we, busy});
    end
    n_vec++;
    if (err_cnt !== 8'd0 || resp_o !== 34'h0 || bus_addr !== 7'h0 || bus_wdata !== 32'h0) begin
      n_err++; $display("FAIL reset_data got err=%0d resp=%h addr=%h wdata=%h want zeros", err_cnt, resp_o, bus_addr, bus_wdata);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  op   [8] = '{2'd1, 2'd2, 2'd1, 2'd3, 2'd0, 2'd1, 2'd1, 2'd2};
    logic [6:0]  ad   [8] = '{7'h10, 7'h04, 7'h02, 7'h10, 7'h7F, 7'h43, 7'h44, 7'h20};
    logic [31:0] dt   [8] = '{32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5};
    int          gg   [8] = '{0, 0, 0, 0, 0, 2, 0, 1};
    int          rr   [8] = '{1, 1, 1, 1, 1, 3, 1, 1};
    logic        ee   [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] rdv  [8] = '{32'hDEADBEEF, 32'h55, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0, 32'hFFFFFFFF};
    logic [33:0] xr   [8] = '{{32'hDEADBEEF, 2'h0}, {32'h0, 2'h2}, {32'h0, 2'h2}, {32'h0, 2'h2},
                              {32'h0, 2'h0}, {32'h12345678, 2'h0}, {32'h0, 2'h2}, {32'h0, 2'h0}};
    int          xl   [8] = '{3, 3, 1, 1, 1, 7, 1, 4};
    int          xq   [8] = '{1, 1, 0, 0, 0, 3, 0, 2};
    int          xe   [8] = '{0, 1, 2, 3, 3, 3, 4, 4};
    logic [33:0] rsp;
    int lat, reqc;
    bit fo, rlo, so;
    logic ra, rf, vf;
    for (int i = 0; i < 8; i++) begin
      do_txn(op[i], ad[i], dt[i], gg[i], rr[i], ee[i], rdv[i], 0, rsp, lat, reqc, fo, rlo, so, ra, rf, vf);
      n_vec++;
      if (rsp !== xr[i] || lat != xl[i] || reqc != xq[i]) begin
        n_err++; $display("FAIL dir%0d got resp=%h lat=%0d req=%0d want resp=%h lat=%0d req=%0d", i, rsp, lat, reqc, xr[i], xl[i], xq[i]);
      end
      n_vec++;
      if (!fo || err_cnt !== 8'(xe[i])) begin
        n_err++; $display("FAIL dir%0d_bus got fields_ok=%0d err_cnt=%0d want 1/%0d", i, fo, err_cnt, xe[i]);
      end
    end
    exp_err = 4;
  endtask

  task automatic test_timeout;
    int          gg [3] = '{-1, 2, 2};
    int          rr [3] = '{1, 5, 6};
    logic [33:0] xr [3] = '{{32'h0, 2'h2}, {32'hCAFE0001, 2'h0}, {32'h0, 2'h2}};
    int          xq [3] = '{8, 3, 3};
    logic [33:0] rsp;
    int lat, reqc;
    bit fo, rlo, so;
    logic ra, rf, vf;
    for (int i = 0; i < 3; i++) begin
      do_txn(2'd1, 7'h10, 32'h0, gg[i], rr[i], 1'b0, 32'hCAFE0001, 0, rsp, lat, reqc, fo, rlo, so, ra, rf, vf);
      if (xr[i][1:0] == 2'h2) exp_err++;
      n_vec++;
      if (rsp !== xr[i] || lat != TMO + 1 || reqc != xq[i]) begin
        n_err++; $display("FAIL tmo%0d got resp=%h lat=%0d req=%0d want resp=%h lat=%0d req=%0d", i, rsp, lat, reqc, xr[i], TMO + 1, xq[i]);
      end
    end
    // Late completion arriving after the aborted transaction has closed.
    bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'h77;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || err_cnt !== 8'(exp_err)) begin
      n_err++; $display("FAIL late_rvalid got busy=%b vld=%b rdy=%b err=%0d want 0/0/1/%0d", busy, resp_valid, req_ready, err_cnt, exp_err);
    end
  endtask

  task automatic test_resp_hold;
    logic [33:0] rsp;
    int lat, reqc;
    bit fo, rlo, so;
    logic ra, rf, vf;
    do_txn(2'd1, 7'h30, 32'h0, 1, 2, 1'b0, 32'h600DF00D, 10, rsp, lat, reqc, fo, rlo, so, ra, rf, vf);
    n_vec++;
    if (rsp !== {32'h600DF00D, 2'h0} || lat != 5) begin
      n_err++; $display("FAIL hold_resp got resp=%h lat=%0d want %h/5", rsp, lat, {32'h600DF00D, 2'h0});
    end
    n_vec++;
    if (!so || !rlo || ra !== 1'b1 || rf !== 1'b1 || vf !== 1'b0) begin
      n_err++; $display("FAIL hold_hs got stable=%0d rdy_low=%0d rdy_acc=%b rdy_after=%b vld_after=%b want 1/1/1/1/0", so, rlo, ra, rf, vf);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  op;
    logic [6:0]  ad;
    logic [31:0] dt, rd;
    int g, r, hold, lat, reqc, xl, xq;
    logic e;
    logic [33:0] rsp, xr;
    bit fo, rlo, so;
    logic ra, rf, vf;
    for (int i = 0; i < 80; i++) begin
      op   = 2'($urandom_range(0, 3));
      ad   = ($urandom_range(0, 9) < 7) ? 7'($urandom_range(4, 67)) : 7'($urandom_range(0, 127));
      dt   = $urandom;
      rd   = $urandom;
      g    = int'($urandom_range(0, 9));
      r    = int'($urandom_range(1, 6));
      e    = ($urandom_range(0, 3) == 0);
      hold = int'($urandom_range(0, 3));
      model(op, ad, g, r, e, rd, xr, xl, xq);
      do_txn(op, ad, dt, g, r, e, rd, hold, rsp, lat, reqc, fo, rlo, so, ra, rf, vf);
      if (xr[1:0] == 2'h2 && exp_err < 255) exp_err++;
      n_vec++;
      if (rsp !== xr || lat != xl || reqc != xq) begin
        n_err++; $display("FAIL rnd%0d op=%0d a=%h got resp=%h lat=%0d req=%0d want resp=%h lat=%0d req=%0d", i, op, ad, rsp, lat, reqc, xr, xl, xq);
      end
      n_vec++;
      if (!fo || !rlo || !so || ra !== 1'b1 || rf !== 1'b1 || err_cnt !== 8'(exp_err)) begin
        n_err++; $display("FAIL rnd%0d_hs got f=%0d rl=%0d s=%0d ra=%b rf=%b err=%0d want 1/1/1/1/1/%0d", i, fo, rlo, so, ra, rf, err_cnt, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid;
    req_i.addr = 7'h10; req_i.op = DTM_READ; req_i.data = 32'h0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    bus_gnt = bus_req;
    @(negedge clk);
    bus_gnt = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || bus_req !== 1'b0 || resp_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_wait got busy=%b req=%b vld=%b want 1/0/0", busy, bus_req, resp_valid);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_err = 0;
    n_vec++;
    if ({req_ready, busy, bus_req, resp_valid} !== 4'b1000 || err_cnt !== 8'd0) begin
      n_err++; $display("FAIL mid_reset got rdy/busy/req/vld=%b err=%0d want 1000/0", {req_ready, busy, bus_req, resp_valid}, err_cnt);
    end
  endtask

  task automatic test_err_sat;
    logic [33:0] rsp;
    int lat, reqc;
    bit fo, rlo, so;
    logic ra, rf, vf;
    for (int i = 0; i < 260; i++) begin
      do_txn(2'd3, 7'h10, 32'h0, 0, 1, 1'b0, 32'h0, 0, rsp, lat, reqc, fo, rlo, so, ra, rf, vf);
      if (i == 253) begin
        n_vec++;
        if (err_cnt !== 8'd254) begin
          n_err++; $display("FAIL err_cnt_254 got %0d want 254", err_cnt);
        end
      end
    end
    n_vec++;
    if (err_cnt !== 8'hFF) begin
      n_err++; $display("FAIL err_cnt_sat got %0d want 255", err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid();
    test_err_sat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
